regfile_arbiter: RTL and testbench



---
 rtl/regfile_arb_pkg.sv | 17 +
 rtl/regfile_arbiter_rr_arb2.sv | 28 ++
 rtl/regfile_arbiter.sv | 93 +++++++++
 tb/tb_regfile_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register file arbiter.
// Optional macro REGFILE_ARB_RR_EN selects round-robin arbitration.
package regfile_arb_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 5;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        XFER
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way arbiter: masked requests plus last-grant pointer in, one-hot grant out.
// REGFILE_ARB_RR_EN: round-robin; otherwise port A has fixed priority.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // pick one requester; on contention favour the port not granted last
    always_comb begin
        grant = '0;
        if (req[PORT_A] && req[PORT_B]) begin
`ifdef REGFILE_ARB_RR_EN
            if (last == 1'(PORT_B)) grant[PORT_A] = 1'b1;
            else                    grant[PORT_B] = 1'b1;
`else
            grant[PORT_A] = 1'b1;
`endif
        end else if (req[PORT_A]) begin
            grant[PORT_A] = 1'b1;
        end else if (req[PORT_B]) begin
            grant[PORT_B] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the 32x8 register file between ports A and B, sequencing each op.
// Optional macro REGFILE_ARB_RR_EN enables round-robin arbitration.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [DW-1:0] rdata,
    output logic          f_we,
    output logic [AW-1:0] fsel,
    output logic [DW-1:0] fin,
    input  logic [DW-1:0] regfile_out
);

    state_t        state;
    logic          op_port;
    logic          op_we;
    logic [DW-1:0] op_wdata;
    logic          last;
    logic [1:0]    req_m;
    logic [1:0]    grant;

    // a port still holds req during its ack cycle, so keep it out of that round
    assign req_m = {req_b & ~ack_b, req_a & ~ack_a};

    rr_arb2 u_arb (
        .req   (req_m),
        .last  (last),
        .grant (grant)
    );

    // sequencer: f_we drops only in XFER of a write, every output registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            f_we     <= 1'b1;
            fsel     <= '0;
            fin      <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            rdata    <= '0;
            last     <= 1'(PORT_B);
            op_port  <= 1'b0;
            op_we    <= 1'b0;
            op_wdata <= '0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        state    <= ADDR;
                        op_port  <= grant[PORT_B];
                        last     <= grant[PORT_B];
                        op_we    <= grant[PORT_B] ? we_b    : we_a;
                        op_wdata <= grant[PORT_B] ? wdata_b : wdata_a;
                        fsel     <= grant[PORT_B] ? addr_b  : addr_a;
                    end
                end
                ADDR: begin
                    state <= XFER;
                    if (op_we) begin
                        f_we <= 1'b0;
                        fin  <= op_wdata;
                    end
                end
                XFER: begin
                    state <= IDLE;
                    f_we  <= 1'b1;
                    fin   <= '0;
                    if (op_port) ack_b <= 1'b1;
                    else         ack_a <= 1'b1;
                    if (!op_we) rdata <= regfile_out;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register file model, op-timeline reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [4:0] addr_a = 0, addr_b = 0;
    logic [7:0] wdata_a = 0, wdata_b = 0;
    logic       ack_a, ack_b, f_we;
    logic [7:0] rdata, fin, regfile_out;
    logic [4:0] fsel;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a       (req_a),
        .we_a        (we_a),
        .addr_a      (addr_a),
        .wdata_a     (wdata_a),
        .req_b       (req_b),
        .we_b        (we_b),
        .addr_b      (addr_b),
        .wdata_b     (wdata_b),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .rdata       (rdata),
        .f_we        (f_we),
        .fsel        (fsel),
        .fin         (fin),
        .regfile_out (regfile_out)
    );

    // register file: latch address while f_we=1, write fin while f_we=0
    logic [7:0] rf_mem [32] = '{default: 8'h00};
    logic [4:0] rf_lat = '0;
    always @(posedge clk) begin
        if (f_we) rf_lat <= fsel;
        else      rf_mem[rf_lat] <= fin;
    end
    assign regfile_out = rf_mem[rf_lat];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference model: each granted op is one record (start cycle s);
    // ADDR at s+1, XFER at s+2, ack at s+3 where the next op may start
    int         cyc = 0;
    int         op_s = 0;
    bit         have_op = 0;
    bit         op_p = 0;
    bit         op_we = 0;
    bit         m_last = 1;
    logic [4:0] op_a = '0;
    logic [7:0] op_d = '0;
    logic [7:0] gmem [32] = '{default: 8'h00};
    logic [7:0] m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin : model
        bit free, acking, ra, rb, pb;
        if (!rst_n) begin
            cyc     <= 0;
            have_op <= 0;
            m_last  <= 1;
        end else begin
            acking = have_op && (cyc == op_s + 3);
            free   = !have_op || (cyc >= op_s + 3);
            ra = req_a && !(acking && !op_p);
            rb = req_b && !(acking && op_p);
            if (ra && rb) pb = RR ? !m_last : 1'b0;
            else          pb = rb;
            if (free && (ra || rb)) begin
                have_op <= 1;
                op_s    <= cyc;
                op_p    <= pb;
                m_last  <= pb;
                op_we   <= pb ? we_b : we_a;
                op_a    <= pb ? addr_b : addr_a;
                op_d    <= pb ? wdata_b : wdata_a;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk or negedge rst_n) begin : cmp
        logic       e_fwe, ea, eb;
        logic [4:0] e_fsel;
        logic [7:0] e_fin;
        if (!rst_n) begin
            m_rdata = '0;
        end else begin
            e_fwe = 1; e_fsel = '0; e_fin = '0; ea = 0; eb = 0;
            if (have_op) begin
                e_fsel = op_a;
                if (op_we && cyc == op_s + 2) begin
                    e_fwe = 0;
                    e_fin = op_d;
                end
                if (cyc == op_s + 3) begin
                    if (op_p) eb = 1; else ea = 1;
                    if (op_we) gmem[op_a] = op_d;
                    else       m_rdata = gmem[op_a];
                end
            end
            chk("m_f_we", f_we, e_fwe);
            chk("m_fsel", fsel, e_fsel);
            chk("m_fin", fin, e_fin);
            chk("m_ack_a", ack_a, ea);
            chk("m_ack_b", ack_b, eb);
            chk("m_rdata", rdata, m_rdata);
        end
    end

    task automatic drive(input bit p, input bit r, input bit w,
                         input logic [4:0] a, input logic [7:0] d);
        if (!p) begin
            req_a = r; we_a = w; addr_a = a; wdata_a = d;
        end else begin
            req_b = r; we_b = w; addr_b = a; wdata_b = d;
        end
    endtask

    // one op from a fresh cycle; returns rdata, ack latency, first f_we-low cycle
    task automatic do_op(input bit p, input bit w, input logic [4:0] a,
                         input logic [7:0] d, output logic [7:0] rd,
                         output int lat, output int lowc);
        @(negedge clk);
        drive(p, 1, w, a, d);
        lat = 0;
        lowc = -1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (!f_we && lowc < 0) lowc = lat;
            if ((p ? ack_b : ack_a) || lat > 12) break;
        end
        rd = rdata;
        drive(p, 0, 0, 0, 0);
    endtask

    task automatic wr(input bit p, input logic [4:0] a, input logic [7:0] d,
                      input string nm);
        logic [7:0] r;
        int l, c;
        do_op(p, 1, a, d, r, l, c);
        chk(nm, l, 3);
    endtask

    task automatic rd_chk(input bit p, input logic [4:0] a,
                          input logic [7:0] e, input string nm);
        logic [7:0] r;
        int l, c;
        do_op(p, 0, a, 0, r, l, c);
        chk(nm, r, e);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    // both ports request together; report ack cycle of each (0 = none)
    task automatic both(input bit wa, input logic [4:0] aa, input logic [7:0] da,
                        input bit wb, input logic [4:0] ab, input logic [7:0] db,
                        output int ca, output int cb);
        int n;
        @(negedge clk);
        drive(0, 1, wa, aa, da);
        drive(1, 1, wb, ab, db);
        n = 0; ca = 0; cb = 0;
        while ((ca == 0 || cb == 0) && n < 20) begin
            @(negedge clk);
            n++;
            if (ack_a && ca == 0) begin ca = n; drive(0, 0, 0, 0, 0); end
            if (ack_b && cb == 0) begin cb = n; drive(1, 0, 0, 0, 0); end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int l, c, ca, cb, acks, issued, n;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_f_we", f_we, 1);
        chk("rst_fsel", fsel, 0);
        chk("rst_fin", fin, 0);
        chk("rst_ack", {ack_a, ack_b}, 0);
        chk("rst_rdata", rdata, 0);
        #2 rst_n = 1;

        // A writes 5 <= A5, B reads it back
        do_op(0, 1, 5, 8'hA5, r, l, c);
        chk("t1_ack_cyc", l, 3);
        chk("t1_fwe_low_cyc", c, 2);
        do_op(1, 0, 5, 0, r, l, c);
        chk("t1_rd_lat", l, 3);
        chk("t1_rdata", r, 8'hA5);

        // long idle: f_we never drops
        repeat (20) begin
            @(negedge clk);
            chk("t4_idle_fwe", f_we, 1);
        end
        rd_chk(1, 5, 8'hA5, "t4_rd5");

        // address boundaries
        wr(0, 31, 8'hFF, "t6_wr31");
        wr(1, 0, 8'h01, "t6_wr0");
        rd_chk(0, 31, 8'hFF, "t6_rd31");
        rd_chk(1, 0, 8'h01, "t6_rd0");

        // reset during XFER of a write kills it
        wr(0, 7, 8'h00, "t5_pre");
        @(negedge clk);
        drive(0, 1, 1, 7, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("t5_xfer_fwe", f_we, 0);
        #2 rst_n = 0;
        #1;
        chk("t5_async_fwe", f_we, 1);
        chk("t5_async_fsel", fsel, 0);
        chk("t5_async_fin", fin, 0);
        chk("t5_async_rdata", rdata, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_no_ack", ack_a, 0);
        #2 rst_n = 1;
        do_op(1, 0, 7, 0, r, l, c);
        chk("t5_idle_after", l, 3);
        chk("t5_rd7", r, 8'h00);

        // simultaneous writes after reset
        pulse_reset();
        both(1, 1, 8'h11, 1, 2, 8'h22, ca, cb);
        chk("t2_ack_a_cyc", ca, 3);
        chk("t2_ack_b_cyc", cb, 6);
        rd_chk(0, 1, 8'h11, "t2_rd1");
        rd_chk(1, 2, 8'h22, "t2_rd2");

        // continuous traffic: the acked port sits out its ack cycle,
        // so grants alternate starting with A
        pulse_reset();
        @(negedge clk);
        drive(0, 1, 1, 8, 8'h80);
        drive(1, 1, 1, 9, 8'h90);
        issued = 2; acks = 0; n = 0;
        while (acks < 12 && n < 100) begin
            @(negedge clk);
            n++;
            if (ack_a) begin
                chk("t3_grant_a", 0, acks % 2);
                acks++;
                if (issued < 12) begin
                    drive(0, 1, 1, 5'(8 + $urandom_range(0, 7)), 8'($urandom));
                    issued++;
                end else drive(0, 0, 0, 0, 0);
            end
            if (ack_b) begin
                chk("t3_grant_b", 1, acks % 2);
                acks++;
                if (issued < 12) begin
                    drive(1, 1, 1, 5'(8 + $urandom_range(0, 7)), 8'($urandom));
                    issued++;
                end else drive(1, 0, 0, 0, 0);
            end
        end
        chk("t3_acks", acks, 12);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // fresh contention right after an A grant
        wr(0, 3, 8'h33, "arb_pre");
        repeat (2) @(negedge clk);
        both(0, 1, 0, 0, 2, 0, ca, cb);
        chk("arb_first_is_b", (cb != 0 && cb < ca), RR);
        chk("arb_second_lat", (ca > cb) ? ca - cb : cb - ca, 3);

        // randomized traffic on both ports
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (ack_a) begin
                if ($urandom_range(0, 1) == 1)
                    drive(0, 1, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 8'($urandom));
                else drive(0, 0, 0, 0, 0);
            end else if (!req_a && $urandom_range(0, 2) == 0) begin
                drive(0, 1, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 8'($urandom));
            end
            if (ack_b) begin
                if ($urandom_range(0, 1) == 1)
                    drive(1, 1, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 8'($urandom));
                else drive(1, 0, 0, 0, 0);
            end else if (!req_b && $urandom_range(0, 2) == 0) begin
                drive(1, 1, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 8'($urandom));
            end
        end
        n = 0;
        while ((req_a || req_b) && n < 30) begin
            @(negedge clk);
            n++;
            if (ack_a) drive(0, 0, 0, 0, 0);
            if (ack_b) drive(1, 0, 0, 0, 0);
        end
        chk("rand_drain", {req_a, req_b}, 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
